// File: rtl/pi_leaf_inject_arb.sv
// Leaf injection scheduler: round-robin with burst cap, delivery, top-priority reinjection.
// Optional statistics counters are enabled by defining PI_LEAF_ARB_STATS_EN.
module pi_leaf_inject_arb #(
  parameter int unsigned num_req    = 4,
  parameter int unsigned p_sz       = 52,
  parameter int unsigned payload_sz = 43,
  parameter int unsigned addr       = 0,
  parameter int unsigned max_burst  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [num_req-1:0]      req_valid,
  input  logic [num_req*p_sz-1:0] req_pkt,
  output logic [num_req-1:0]      req_ready,
  input  logic [p_sz-1:0]         bus_i,
  output logic [p_sz-1:0]         bus_o,
  input  logic                    deliver_rdy,
  output logic [p_sz-1:0]         deliver_pkt
`ifdef PI_LEAF_ARB_STATS_EN
  ,
  output logic [31:0]             stat_inj,
  output logic [31:0]             stat_dlv,
  output logic [31:0]             stat_bnc
`endif
);

  localparam int unsigned AW = p_sz - 1 - payload_sz;
  localparam int unsigned PW = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int unsigned CW = $clog2(max_burst + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StReinject} state_e;

  state_e            w_state;
  logic              r_bnc_vld;
  logic [p_sz-1:0]   r_bnc;
  logic [PW-1:0]     r_ptr, r_owner, w_winner, w_ptr_next;
  logic [CW-1:0]     r_cnt, w_cnt_inc;
  logic [num_req-1:0] w_grant;
  logic [p_sz-1:0]   w_pkt;
  logic              w_arr_vld, w_dlv, w_bounce;
  int unsigned       w_idx;
  logic              w_found;

  // Bounce reg has absolute priority over local requesters.
  always_comb begin
    if (r_bnc_vld)       w_state = StReinject;
    else if (|req_valid) w_state = StGrant;
    else                 w_state = StIdle;
  end

  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int unsigned k = 0; k < num_req; k++) begin
      w_idx = (32'(r_ptr) + k) % num_req;
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_state == StGrant && !reset) w_grant[w_winner] = 1'b1;
  end

  assign req_ready  = w_grant;
  assign w_pkt      = req_pkt[32'(w_winner)*p_sz +: p_sz];
  assign w_cnt_inc  = (w_winner == r_owner) ? r_cnt + CW'(1) : CW'(1);
  assign w_ptr_next = (w_winner == PW'(num_req - 1)) ? '0 : w_winner + PW'(1);

  assign w_arr_vld = bus_i[p_sz-1];
  assign w_dlv     = w_arr_vld && (bus_i[p_sz-2:payload_sz] == AW'(addr)) && deliver_rdy;
  assign w_bounce  = w_arr_vld && !w_dlv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_o       <= '0;
      deliver_pkt <= '0;
      r_bnc       <= '0;
      r_bnc_vld   <= 1'b0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
    end else begin
      deliver_pkt <= w_dlv ? bus_i : '0;
      // A draining bounce reg may be refilled on the same edge.
      if (w_bounce) begin
        r_bnc     <= bus_i;
        r_bnc_vld <= 1'b1;
      end else if (w_state == StReinject) begin
        r_bnc_vld <= 1'b0;
      end
      unique case (w_state)
        StReinject: bus_o <= r_bnc;
        StGrant: begin
          bus_o   <= {1'b1, w_pkt[p_sz-2:0]};
          r_owner <= w_winner;
          if (w_cnt_inc == CW'(max_burst)) begin
            r_ptr <= w_ptr_next;
            r_cnt <= '0;
          end else begin
            r_ptr <= w_winner;
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          bus_o <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PI_LEAF_ARB_STATS_EN
  logic [31:0] r_inj, r_dlv, r_bnc_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inj     <= '0;
      r_dlv     <= '0;
      r_bnc_cnt <= '0;
    end else begin
      if (w_state == StGrant && r_inj != '1) r_inj <= r_inj + 32'd1;
      if (w_dlv && r_dlv != '1)              r_dlv <= r_dlv + 32'd1;
      if (w_bounce && r_bnc_cnt != '1)       r_bnc_cnt <= r_bnc_cnt + 32'd1;
    end
  end

  assign stat_inj = r_inj;
  assign stat_dlv = r_dlv;
  assign stat_bnc = r_bnc_cnt;
`endif

endmodule

// File: tb/tb_pi_leaf_inject_arb.sv
// Self-checking bench for pi_leaf_inject_arb: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pi_leaf_inject_arb;

  localparam int N  = 4;
  localparam int PS = 52;
  localparam int PL = 43;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*PS-1:0] req_pkt = '0;
  logic [N-1:0]    req_ready;
  logic [PS-1:0]   bus_i = '0;
  logic [PS-1:0]   bus_o;
  logic            deliver_rdy = 1'b0;
  logic [PS-1:0]   deliver_pkt;
`ifdef PI_LEAF_ARB_STATS_EN
  logic [31:0]     stat_inj, stat_dlv, stat_bnc;
`endif

  always #5 clk = ~clk;

  pi_leaf_inject_arb #(
    .num_req(N), .p_sz(PS), .payload_sz(PL), .addr(0), .max_burst(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_pkt(req_pkt),
    .req_ready(req_ready),
    .bus_i(bus_i),
    .bus_o(bus_o),
    .deliver_rdy(deliver_rdy),
    .deliver_pkt(deliver_pkt)
`ifdef PI_LEAF_ARB_STATS_EN
    ,
    .stat_inj(stat_inj),
    .stat_dlv(stat_dlv),
    .stat_bnc(stat_bnc)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int            m_ptr, m_owner, m_cnt, m_win;
  logic [PS-1:0] m_bq[$];
  logic [PS-1:0] m_bus, m_dlv;
  logic [N-1:0]  m_ready;
  int            m_inj, m_dlvc, m_bnc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [PS-1:0] mk(input int dest, input logic [63:0] pl);
    logic [7:0] d;
    d = dest[7:0];
    return {1'b1, d, pl[PL-1:0]};
  endfunction

  function automatic logic [PS-1:0] rnd_pkt();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[PS-1:0];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0;
    m_bq.delete();
    m_bus = '0; m_dlv = '0; m_ready = '0;
    m_inj = 0; m_dlvc = 0; m_bnc = 0;
  endtask

  // One cycle of the spec's rules, applied to the inputs currently driven.
  task automatic model_step();
    m_ready = '0;
    m_win = -1;
    if (m_bq.size() > 0) begin
      m_bus = m_bq.pop_front();
    end else if (req_valid != '0) begin
      for (int k = 0; k < N; k++)
        if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      m_ready[m_win] = 1'b1;
      m_bus = req_pkt[m_win*PS +: PS];
      m_bus[PS-1] = 1'b1;
      m_inj++;
      m_cnt = (m_win == m_owner) ? m_cnt + 1 : 1;
      m_owner = m_win;
      if (m_cnt == MB) begin
        m_ptr = (m_win + 1) % N;
        m_cnt = 0;
      end else begin
        m_ptr = m_win;
      end
    end else begin
      m_bus = '0;
      m_cnt = 0;
    end
    m_dlv = '0;
    if (bus_i[PS-1]) begin
      if (bus_i[PS-2:PL] == 8'd0 && deliver_rdy) begin
        m_dlv = bus_i;
        m_dlvc++;
      end else begin
        m_bq.push_back(bus_i);
        m_bnc++;
      end
    end
  endtask

  task automatic cycle(input string tag);
    #1;
    model_step();
    chk({tag, ".ready"}, 64'(req_ready), 64'(m_ready));
    @(posedge clk);
    #1;
    chk({tag, ".bus_o"}, 64'(bus_o), 64'(m_bus));
    chk({tag, ".deliver"}, 64'(deliver_pkt), 64'(m_dlv));
`ifdef PI_LEAF_ARB_STATS_EN
    chk({tag, ".stat_inj"}, 64'(stat_inj), 64'(m_inj));
    chk({tag, ".stat_dlv"}, 64'(stat_dlv), 64'(m_dlvc));
    chk({tag, ".stat_bnc"}, 64'(stat_bnc), 64'(m_bnc));
`endif
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, ".rst_bus_o"}, 64'(bus_o), 64'd0);
    chk({tag, ".rst_deliver"}, 64'(deliver_pkt), 64'd0);
    chk({tag, ".rst_ready"}, 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Accepted requesters get a fresh packet; held-high ones keep theirs.
  task automatic refill_accepted();
    for (int i = 0; i < N; i++)
      if (m_ready[i]) req_pkt[i*PS +: PS] = rnd_pkt();
  endtask

  logic [N-1:0]  exp_gnt;
  logic [PS-1:0] pkt_a;

  initial begin
    model_reset();
    // 1: reset with all inputs low
    @(posedge clk);
    do_reset("t1");

    // 2: all four requesting, burst of 4 each
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_pkt[i*PS +: PS] = rnd_pkt();
    for (int i = 0; i < 20; i++) begin
      exp_gnt = 4'b0001 << ((i / MB) % N);
      #1;
      chk("t2.grant_seq", 64'(req_ready), 64'(exp_gnt));
      cycle("t2");
      refill_accepted();
    end

    // mid-operation reset restarts arbitration at 0
    do_reset("t_midrst");

    // 3: only 1 and 3 requesting
    req_valid = 4'b1010;
    for (int i = 0; i < 12; i++) begin
      exp_gnt = ((i / MB) % 2 == 1) ? 4'b1000 : 4'b0010;
      #1;
      chk("t3.grant_seq", 64'(req_ready), 64'(exp_gnt));
      cycle("t3");
      refill_accepted();
    end
    req_valid = '0;
    cycle("t3.idle");

    // 4: delivery to this leaf
    pkt_a = mk(0, {$urandom, $urandom});
    bus_i = pkt_a;
    deliver_rdy = 1'b1;
    cycle("t4");
    chk("t4.deliver_direct", 64'(deliver_pkt), 64'(pkt_a));
    chk("t4.bus_o_quiet", 64'(bus_o), 64'd0);
    bus_i = '0;
    cycle("t4.after");

    // 5: wrong destination bounces past a waiting requester
    req_valid = 4'b0001;
    req_pkt[0 +: PS] = rnd_pkt();
    pkt_a = mk(5, {$urandom, $urandom});
    bus_i = pkt_a;
    cycle("t5.T");
    refill_accepted();
    bus_i = '0;
    #1;
    chk("t5.starved", 64'(req_ready), 64'd0);
    cycle("t5.T1");
    chk("t5.bounce_out", 64'(bus_o), 64'(pkt_a));
    #1;
    chk("t5.regrant", 64'(req_ready), 64'd1);
    cycle("t5.T2");
    refill_accepted();
    req_valid = '0;
    cycle("t5.idle");

    // 6: three back-to-back bounces with sink not ready
    do_reset("t6");
    deliver_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_i = mk(0, {$urandom, $urandom});
      cycle("t6.arr");
    end
    bus_i = '0;
    for (int i = 0; i < 3; i++) cycle("t6.drain");
`ifdef PI_LEAF_ARB_STATS_EN
    chk("t6.stat_bnc3", 64'(stat_bnc), 64'd3);
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_ready[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          req_pkt[i*PS +: PS] = rnd_pkt();
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 9) < 4)
        bus_i = mk(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 255), {$urandom, $urandom});
      else
        bus_i = {1'b0, rnd_pkt() >> 1};
      deliver_rdy = ($urandom_range(0, 9) < 7);
      cycle("rnd");
      if (c == 700) begin
        req_valid = '0;
        do_reset("rnd_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
